// File: rtl/cmp_ge_serial_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package cmp_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_serial_state_e;

    // Digit counter width: enough bits to count N digits, never less than one.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/CmpGE.sv
// Combinational unsigned comparator GE = (A >= B).
// speed != 0 maps to a flat magnitude compare (synthesis builds a prefix tree);
// speed == 0 uses a compact LSB-first generate/propagate ripple chain.
module CmpGE #(
    parameter int width = 8,
    parameter int speed = 1
) (
    input  logic [width-1:0] A_i,
    input  logic [width-1:0] B_i,
    output logic             GE_o
);

    generate
        if (speed != 0) begin : g_fast
            assign GE_o = (A_i >= B_i);
        end else begin : g_ripple
            logic ge_s;

            // Ripple from LSB: a higher differing bit overrides the lower result.
            always_comb begin
                ge_s = 1'b1;
                for (int i = 0; i < width; i++) begin
                    ge_s = (A_i[i] & ~B_i[i]) | (~(A_i[i] ^ B_i[i]) & ge_s);
                end
            end

            assign GE_o = ge_s;
        end
    endgenerate

endmodule

// File: rtl/cmp_ge_serial_digit.sv
// Per-cycle digit comparator: magnitude via CmpGE, equality via XNOR reduction.
module cmp_ge_serial_digit #(
    parameter int digit = 2,
    parameter int speed = 1
) (
    input  logic [digit-1:0] a_i,
    input  logic [digit-1:0] b_i,
    output logic             ge_o,
    output logic             eq_o
);

    CmpGE #(
        .width (digit),
        .speed (speed)
    ) u_cmp_ge (
        .A_i  (a_i),
        .B_i  (b_i),
        .GE_o (ge_o)
    );

    assign eq_o = &(a_i ~^ b_i);

endmodule

// File: rtl/cmp_ge_serial.sv
// Digit-serial unsigned comparator: scans A and B MSB-first, `digit` bits per
// cycle, and reports GE = (A >= B) and EQ = (A == B) over valid/ready handshakes.
module cmp_ge_serial
    import cmp_pkg::*;
#(
    parameter int width      = 8,
    parameter int digit      = 2,
    parameter int early_exit = 1,
    parameter int speed      = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [width-1:0] A_i,
    input  logic [width-1:0] B_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             GE_o,
    output logic             EQ_o
);

    localparam int N = width / digit;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if ((width < 1) || (digit < 1) || ((width % digit) != 0)) begin : g_bad_params
            $error("cmp_ge_serial: width must be >= 1 and a multiple of digit");
        end
    endgenerate

    cmp_serial_state_e state_q, state_d;
    logic [width-1:0]  a_q, a_d;
    logic [width-1:0]  b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dec_q, dec_d;
    logic              ge_q, ge_d;
    logic              eq_q, eq_d;

    logic              dig_ge_s;
    logic              dig_eq_s;
    logic              new_dec_s;

    cmp_ge_serial_digit #(
        .digit (digit),
        .speed (speed)
    ) u_digit (
        .a_i  (a_q[width-1 -: digit]),
        .b_i  (b_q[width-1 -: digit]),
        .ge_o (dig_ge_s),
        .eq_o (dig_eq_s)
    );

    // First difference seen while still undecided fixes the result.
    assign new_dec_s = ~dec_q & ~dig_eq_s;

    // Next-state and datapath update for the IDLE/SCAN/DONE controller.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        ge_d    = ge_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = A_i;
                    b_d     = B_i;
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (new_dec_s) begin
                    ge_d  = dig_ge_s;
                    eq_d  = 1'b0;
                    dec_d = 1'b1;
                end else begin
                    dec_d = dec_q;
                end
                a_d   = a_q << digit;
                b_d   = b_q << digit;
                cnt_d = cnt_q + CNT_ONE;
                if (((early_exit != 0) && new_dec_s) || (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                    if (!dec_q && !new_dec_s) begin
                        // Every digit matched: operands are equal.
                        ge_d = 1'b1;
                        eq_d = 1'b1;
                    end else begin
                        dec_d = 1'b1;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            ge_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            ge_q    <= ge_d;
            eq_q    <= eq_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign GE_o        = ge_q;
    assign EQ_o        = eq_q;

endmodule

// File: doc/cmp_ge_serial.md
# cmp_ge_serial

Sequential, digit-serial counterpart of the combinational `CmpGE` magnitude comparator.
- Accepts one operand pair through a valid/ready handshake.
- Scans the operands MSB-first, `digit` bits per cycle, in the opposite direction to the LSB-first generate/propagate chain.
- Returns GE = (A >= B) and EQ = (A == B) through a second valid/ready handshake.
- Used where a full-width prefix comparator is too large and result latency is acceptable, e.g. iterative dividers and sort/merge units.

## Interface
Parameters:
- `width`, 8: operand width; must be ≥ 1.
- `digit`, 2: bits compared per cycle; `width % digit == 0` is required, enforced by an elaboration-time assertion.
- `early_exit`, 1: 1 = finish at the first differing digit; 0 = fixed latency of `width/digit` scan cycles.
- `speed`, 1: forwarded to the digit comparator's prefix structure.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `in_valid_i` in 1: operand pair valid.
- `in_ready_o` out 1: block can accept operands.
- `A_i` in `width`: operand A, unsigned.
- `B_i` in `width`: operand B, unsigned.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `GE_o` out 1: A >= B.
- `EQ_o` out 1: A == B.

## Operation
- Let N = `width/digit`.
- The FSM has three states: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready_o` = 1.
  - On `in_valid_i & in_ready_o`: register A and B into shift registers, clear the digit counter and the decided flag, go to SCAN.
- SCAN, evaluated each cycle on the top `digit` bits (a, b) of the shift registers:
  - If not yet decided and a != b: latch GE = (a >= b), EQ = 0, set decided.
  - If not yet decided and a == b: no change to GE/EQ.
  - Shift both registers left by `digit`, zero-filling, and increment the counter.
  - Go to DONE when `early_exit` = 1 and a difference is found this cycle, or when the counter reaches N−1.
  - If still undecided at the end of the scan: GE = 1, EQ = 1.
  - When `early_exit` = 0, digits after the decision are scanned but do not alter GE/EQ.
- DONE:
  - `out_valid_o` = 1; `GE_o`/`EQ_o` stay stable until the transfer.
  - On `out_ready_i` go to IDLE.
- `in_ready_o` is 0 in SCAN and DONE. `in_valid_i` is ignored there and never queued; A_i/B_i are don't-care outside the input handshake.
- `GE_o`/`EQ_o` are valid only while `out_valid_o` = 1. They hold their last value otherwise.
- Reset at any edge, including mid-SCAN or in DONE:
  - The state goes to IDLE and the in-flight operation is discarded.
  - `out_valid_o` = 0, `GE_o` = 0, `EQ_o` = 0, `in_ready_o` = 1.
  - The counter and shift registers are cleared.

## Timing
- The input handshake happens on edge T0.
- With `early_exit` = 1 and the first difference in digit k (0 = MSB digit), `out_valid_o` rises after edge T0+k+1.
- With all digits equal, or with `early_exit` = 0, `out_valid_o` rises after edge T0+N.
- The output handshake completes on edge Tn when `out_valid_o & out_ready_i`.
- `in_ready_o` = 1 from the cycle after Tn. Throughput is one operation per (latency+1) cycles at best.
- There is no combinational path from any input to any output. All outputs are registered or decoded from the state register.
- When `width == digit` (N = 1), latency is exactly 1 scan cycle in both modes.

## Structure
- Package `cmp_pkg` holds the FSM state enum `cmp_serial_state_e` (IDLE, SCAN, DONE).
- The counter width is a local constant, `$clog2(N)` bits with a minimum of 1.
- One sub-module:
  - Digit comparison instantiates the existing `CmpGE #(.width(digit), .speed(speed))` on the top digits.
  - Digit equality is a local XNOR reduction.

## Test plan
Unless stated otherwise, the bench uses `width`=8, `digit`=2, `early_exit`=1.
- A=0xA5, B=0x5A: the first digit differs (10 vs 01). Expect `out_valid_o` high in the cycle after T0+1, GE=1, EQ=0.
- A=0x3C, B=0x3C: all digits equal. Expect `out_valid_o` after T0+4, GE=1, EQ=1.
- A=0x10, B=0x11: the difference is in the last digit. Expect `out_valid_o` after T0+4, GE=0, EQ=0. Repeat with `early_exit`=0 and A=0xFF, B=0x00: expect latency 4, GE=1.
- Hold `out_ready_i`=0 for 5 cycles in DONE while pulsing `in_valid_i` with new operands. Expect `out_valid_o` to stay 1, GE/EQ stable, `in_ready_o`=0, and the new operands never accepted.
- Drop `rst_ni` low for one edge mid-SCAN. Expect `out_valid_o`=0, GE=0, EQ=0, `in_ready_o`=1 the next cycle. A following operation with A=0x01, B=0x80 yields GE=0.
- Exhaustive run for `width`=4 with `digit` in {1,2,4}, plus 10k random pairs at `width`=32, `digit`=4, with random back-pressure. Each result must match `A >= B` and `A == B` from the behavioural model.
